// File: rtl/acc_channel_scheduler.sv
// Round-robin phase-accumulator scheduler: one shared adder serves NUM_CH channels.
// Configuration writes are admitted only outside the scan (IDLE, or a one-cycle CFG slot).
module acc_channel_scheduler #(
   parameter int NUM_CH    = 4,
   parameter int ACC_WIDTH = 16,
   parameter int ADD_WIDTH = 16,
   parameter int CH_BITS   = $clog2(NUM_CH)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 run,
   input  logic                 cfg_valid,
   output logic                 cfg_ready,
   input  logic [CH_BITS-1:0]   cfg_ch,
   input  logic [ADD_WIDTH-1:0] cfg_inc,
   input  logic                 cfg_en,
   output logic [CH_BITS-1:0]   slot,
   output logic                 frame_tick,
   output logic                 out_valid,
   output logic [CH_BITS-1:0]   out_ch,
   output logic [ACC_WIDTH-1:0] out_acc,
   output logic [NUM_CH-1:0]    msb_out
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SCAN = 2'd1,
      ST_CFG  = 2'd2
   } state_t;

   localparam logic [CH_BITS-1:0] SLOT_LAST  = CH_BITS'(NUM_CH - 1);
   localparam logic [CH_BITS-1:0] SLOT_ONE   = CH_BITS'(1);
   localparam logic [CH_BITS:0]   NUM_CH_EXT = (CH_BITS + 1)'(NUM_CH);

   state_t                 state_r;
   logic [CH_BITS-1:0]     slot_r;
   logic [ACC_WIDTH-1:0]   acc_r [NUM_CH];
   logic [ADD_WIDTH-1:0]   inc_r [NUM_CH];
   logic [NUM_CH-1:0]      en_r;
   logic                   out_valid_r;
   logic [CH_BITS-1:0]     out_ch_r;
   logic [ACC_WIDTH-1:0]   out_acc_r;
   logic                   frame_tick_r;

   logic                   cfg_ready_s;
   logic                   cfg_fire_s;
   logic [ACC_WIDTH-1:0]   inc_ext_s;
   logic [ACC_WIDTH-1:0]   acc_sum_s;
   logic [ACC_WIDTH-1:0]   acc_new_s;
   logic [NUM_CH-1:0]      msb_s;

   // Configuration is accepted whenever the scan is not using the datapath
   always_comb begin
      cfg_ready_s = 1'b0;
      case (state_r)
         ST_IDLE: cfg_ready_s = 1'b1;
         ST_SCAN: cfg_ready_s = 1'b0;
         ST_CFG:  cfg_ready_s = 1'b1;
         default: cfg_ready_s = 1'b0;
      endcase
   end

   // Writes aimed past the last channel still complete the handshake but are dropped
   always_comb begin
      if (cfg_valid && cfg_ready_s && ({1'b0, cfg_ch} < NUM_CH_EXT)) begin
         cfg_fire_s = 1'b1;
      end else begin
         cfg_fire_s = 1'b0;
      end
   end

   // Shared adder for the channel in the current slot; disabled channels hold
   always_comb begin
      inc_ext_s = '0;
      inc_ext_s[ADD_WIDTH-1:0] = inc_r[slot_r];
      acc_sum_s = acc_r[slot_r] + inc_ext_s;
      if (en_r[slot_r]) begin
         acc_new_s = acc_sum_s;
      end else begin
         acc_new_s = acc_r[slot_r];
      end
   end

   // Square-wave outputs come straight from the accumulator registers
   always_comb begin
      msb_s = '0;
      for (int k = 0; k < NUM_CH; k++) begin
         msb_s[k] = acc_r[k][ACC_WIDTH-1];
      end
   end

   // Scheduler FSM, accumulator bank and registered result strobe
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r      <= ST_IDLE;
         slot_r       <= '0;
         en_r         <= '0;
         out_valid_r  <= 1'b0;
         out_ch_r     <= '0;
         out_acc_r    <= '0;
         frame_tick_r <= 1'b0;
         for (int k = 0; k < NUM_CH; k++) begin
            acc_r[k] <= '0;
            inc_r[k] <= '0;
         end
      end else begin
         out_valid_r  <= 1'b0;
         frame_tick_r <= 1'b0;
         case (state_r)
            ST_IDLE: begin
               slot_r <= '0;
               if (run) begin
                  state_r <= ST_SCAN;
               end
            end
            ST_SCAN: begin
               acc_r[slot_r] <= acc_new_s;
               out_valid_r   <= 1'b1;
               out_ch_r      <= slot_r;
               out_acc_r     <= acc_new_s;
               if (slot_r == SLOT_LAST) begin
                  frame_tick_r <= 1'b1;
                  slot_r       <= '0;
                  // A pending config wins over stopping; it is serviced before returning to IDLE
                  if (cfg_valid) begin
                     state_r <= ST_CFG;
                  end else if (!run) begin
                     state_r <= ST_IDLE;
                  end else begin
                     state_r <= ST_SCAN;
                  end
               end else begin
                  slot_r <= slot_r + SLOT_ONE;
               end
            end
            ST_CFG: begin
               slot_r <= '0;
               if (run) begin
                  state_r <= ST_SCAN;
               end else begin
                  state_r <= ST_IDLE;
               end
            end
            default: begin
               state_r <= ST_IDLE;
               slot_r  <= '0;
            end
         endcase
         // Only reachable in IDLE or CFG, so never collides with the accumulation above
         if (cfg_fire_s) begin
            inc_r[cfg_ch] <= cfg_inc;
            en_r[cfg_ch]  <= cfg_en;
            acc_r[cfg_ch] <= '0;
         end
      end
   end

   assign cfg_ready  = cfg_ready_s;
   assign slot       = slot_r;
   assign frame_tick = frame_tick_r;
   assign out_valid  = out_valid_r;
   assign out_ch     = out_ch_r;
   assign out_acc    = out_acc_r;
   assign msb_out    = msb_s;

endmodule

// File: tb/tb_acc_channel_scheduler.sv
// Self-checking bench for acc_channel_scheduler: directed scenarios plus randomized
// configuration/run sequences, checked against a per-channel arithmetic model.
module tb_acc_channel_scheduler;
   localparam int NCH = 4;
   localparam int AW  = 16;
   localparam int CB  = 2;

   logic           clk = 1'b0;
   logic           rst;
   logic           run;
   logic           cfg_valid;
   logic           cfg_ready;
   logic [CB-1:0]  cfg_ch;
   logic [AW-1:0]  cfg_inc;
   logic           cfg_en;
   logic [CB-1:0]  slot;
   logic           frame_tick;
   logic           out_valid;
   logic [CB-1:0]  out_ch;
   logic [AW-1:0]  out_acc;
   logic [NCH-1:0] msb_out;

   int tests  = 0;
   int failed = 0;

   // Reference model: one accumulator, increment and enable per channel
   logic [AW-1:0] m_acc [NCH];
   logic [AW-1:0] m_inc [NCH];
   logic          m_en  [NCH];

   acc_channel_scheduler #(.NUM_CH(NCH), .ACC_WIDTH(AW), .ADD_WIDTH(AW)) dut (
      .clk(clk), .rst(rst), .run(run),
      .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_ch(cfg_ch),
      .cfg_inc(cfg_inc), .cfg_en(cfg_en),
      .slot(slot), .frame_tick(frame_tick), .out_valid(out_valid),
      .out_ch(out_ch), .out_acc(out_acc), .msb_out(msb_out)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic model_clear();
      for (int k = 0; k < NCH; k++) begin
         m_acc[k] = '0;
         m_inc[k] = '0;
         m_en[k]  = 1'b0;
      end
   endtask

   function automatic logic [NCH-1:0] model_msb();
      logic [NCH-1:0] v;
      for (int k = 0; k < NCH; k++) v[k] = m_acc[k][AW-1];
      return v;
   endfunction

   task automatic cfg_write(input int ch, input logic [AW-1:0] inc, input logic en);
      cfg_valid = 1'b1;
      cfg_ch    = CB'(ch);
      cfg_inc   = inc;
      cfg_en    = en;
      tick();
      cfg_valid = 1'b0;
      m_inc[ch] = inc;
      m_en[ch]  = en;
      m_acc[ch] = '0;
   endtask

   // Runs nframes frames from IDLE; run drops before slot drop_slot of the last frame.
   // If cfg_frame >= 0, a config is raised at slot 1 of that frame (must not be the last frame).
   task automatic test_scan_frames(input int nframes, input int drop_slot, input int cfg_frame,
                                   input int c_ch, input logic [AW-1:0] c_inc, input logic c_en);
      int            since;
      int            exp_len;
      logic          exp_ready;
      logic [CB-1:0] exp_slot;
      since   = -1;
      exp_len = NCH;
      run = 1'b1;
      tick();
      tests++;
      if (slot !== 2'd0 || out_valid !== 1'b0 || cfg_ready !== 1'b0) begin
         failed++;
         $display("FAIL scan_entry: slot=%0d out_valid=%0b cfg_ready=%0b, expected 0/0/0",
                  slot, out_valid, cfg_ready);
      end
      for (int f = 0; f < nframes; f++) begin
         for (int k = 0; k < NCH; k++) begin
            if (f == cfg_frame && k == 1) begin
               cfg_valid = 1'b1;
               cfg_ch    = CB'(c_ch);
               cfg_inc   = c_inc;
               cfg_en    = c_en;
            end
            if (f == nframes - 1 && k == drop_slot) run = 1'b0;
            tick();
            if (since >= 0) since++;
            if (m_en[k]) m_acc[k] = m_acc[k] + m_inc[k];
            tests++;
            if (out_valid !== 1'b1 || out_ch !== CB'(k) || out_acc !== m_acc[k]) begin
               failed++;
               $display("FAIL slot_result f=%0d k=%0d: valid=%0b ch=%0d acc=%h, expected 1/%0d/%h",
                        f, k, out_valid, out_ch, out_acc, k, m_acc[k]);
            end
            tests++;
            if (msb_out !== model_msb()) begin
               failed++;
               $display("FAIL msb_out f=%0d k=%0d: got %b expected %b", f, k, msb_out, model_msb());
            end
            exp_slot  = (k == NCH - 1) ? CB'(0) : CB'(k + 1);
            exp_ready = (k == NCH - 1) && (f == cfg_frame || f == nframes - 1);
            tests++;
            if (slot !== exp_slot || frame_tick !== (k == NCH - 1) || cfg_ready !== exp_ready) begin
               failed++;
               $display("FAIL slot_ctrl f=%0d k=%0d: slot=%0d tick=%0b ready=%0b, expected %0d/%0b/%0b",
                        f, k, slot, frame_tick, cfg_ready, exp_slot, (k == NCH - 1), exp_ready);
            end
            if (k == NCH - 1) begin
               if (since >= 0) begin
                  tests++;
                  if (since != exp_len) begin
                     failed++;
                     $display("FAIL frame_len f=%0d: got %0d cycles expected %0d", f, since, exp_len);
                  end
               end
               since   = 0;
               exp_len = NCH;
            end
            if (k == NCH - 1 && f == cfg_frame) begin
               tick();
               since++;
               cfg_valid    = 1'b0;
               m_inc[c_ch]  = c_inc;
               m_en[c_ch]   = c_en;
               m_acc[c_ch]  = '0;
               exp_len      = NCH + 1;
               tests++;
               if (out_valid !== 1'b0 || frame_tick !== 1'b0 || slot !== 2'd0 || cfg_ready !== 1'b0) begin
                  failed++;
                  $display("FAIL cfg_slot f=%0d: valid=%0b tick=%0b slot=%0d ready=%0b, expected 0/0/0/0",
                           f, out_valid, frame_tick, slot, cfg_ready);
               end
            end
         end
      end
      tick();
      tests++;
      if (out_valid !== 1'b0 || frame_tick !== 1'b0 || slot !== 2'd0 || cfg_ready !== 1'b1 ||
          msb_out !== model_msb()) begin
         failed++;
         $display("FAIL scan_exit: valid=%0b tick=%0b slot=%0d ready=%0b msb=%b, expected 0/0/0/1/%b",
                  out_valid, frame_tick, slot, cfg_ready, msb_out, model_msb());
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick();
      tests++;
      if (slot !== 2'd0 || out_valid !== 1'b0 || out_ch !== 2'd0 || out_acc !== 16'h0000 ||
          msb_out !== 4'b0000 || frame_tick !== 1'b0 || cfg_ready !== 1'b1) begin
         failed++;
         $display("FAIL reset_state: slot=%0d valid=%0b ch=%0d acc=%h msb=%b tick=%0b ready=%0b, expected 0/0/0/0000/0000/0/1",
                  slot, out_valid, out_ch, out_acc, msb_out, frame_tick, cfg_ready);
      end
      rst = 1'b0;
      tick();
      tests++;
      if (slot !== 2'd0 || out_valid !== 1'b0 || cfg_ready !== 1'b1) begin
         failed++;
         $display("FAIL reset_release: slot=%0d valid=%0b ready=%0b, expected 0/0/1",
                  slot, out_valid, cfg_ready);
      end
   endtask

   task automatic test_basic_rate();
      cfg_write(1, 16'h4000, 1'b1);
      test_scan_frames(4, 3, -1, 0, 16'h0000, 1'b0);
   endtask

   task automatic test_wrap();
      cfg_write(0, 16'hFFFF, 1'b1);
      test_scan_frames(3, 2, -1, 0, 16'h0000, 1'b0);
   endtask

   task automatic test_cfg_during_scan();
      test_scan_frames(3, 1, 0, 2, 16'h0100, 1'b1);
   endtask

   task automatic test_run_drop();
      cfg_write(2, 16'h1234, 1'b1);
      test_scan_frames(2, 1, -1, 0, 16'h0000, 1'b0);
      for (int i = 0; i < 3; i++) begin
         tick();
         tests++;
         if (out_valid !== 1'b0 || slot !== 2'd0 || msb_out !== model_msb()) begin
            failed++;
            $display("FAIL idle_hold i=%0d: valid=%0b slot=%0d msb=%b, expected 0/0/%b",
                     i, out_valid, slot, msb_out, model_msb());
         end
      end
      test_scan_frames(1, 0, -1, 0, 16'h0000, 1'b0);
   endtask

   task automatic test_enable_off();
      cfg_write(1, 16'h4000, 1'b1);
      test_scan_frames(3, 0, 1, 1, 16'h4000, 1'b0);
   endtask

   task automatic test_random();
      int nw;
      int nf;
      int cf;
      for (int r = 0; r < 8; r++) begin
         nw = int'($urandom_range(3, 1));
         for (int w = 0; w < nw; w++) begin
            cfg_write(int'($urandom_range(NCH - 1, 0)), AW'($urandom), 1'($urandom));
         end
         nf = int'($urandom_range(4, 1));
         cf = -1;
         if (nf >= 2 && $urandom_range(1, 0) == 1) cf = int'($urandom_range(nf - 2, 0));
         test_scan_frames(nf, int'($urandom_range(NCH - 1, 0)), cf,
                          int'($urandom_range(NCH - 1, 0)), AW'($urandom), 1'($urandom));
      end
   endtask

   task automatic test_reset_mid_scan();
      cfg_write(0, 16'h9000, 1'b1);
      cfg_write(3, 16'hC000, 1'b1);
      run = 1'b1;
      tick();
      for (int k = 0; k < 3; k++) begin
         tick();
         if (m_en[k]) m_acc[k] = m_acc[k] + m_inc[k];
      end
      tests++;
      if (msb_out !== model_msb() || slot !== 2'd3) begin
         failed++;
         $display("FAIL pre_reset: msb=%b slot=%0d, expected %b/3", msb_out, slot, model_msb());
      end
      #2;
      rst = 1'b1;
      run = 1'b0;
      #1;
      tests++;
      if (msb_out !== 4'b0000 || out_valid !== 1'b0 || out_acc !== 16'h0000 || frame_tick !== 1'b0) begin
         failed++;
         $display("FAIL reset_async: msb=%b valid=%0b acc=%h tick=%0b, expected 0000/0/0000/0",
                  msb_out, out_valid, out_acc, frame_tick);
      end
      model_clear();
      tick();
      rst = 1'b0;
      tests++;
      if (cfg_ready !== 1'b1 || slot !== 2'd0) begin
         failed++;
         $display("FAIL reset_next: ready=%0b slot=%0d, expected 1/0", cfg_ready, slot);
      end
      test_scan_frames(1, 0, -1, 0, 16'h0000, 1'b0);
   endtask

   initial begin
      rst       = 1'b0;
      run       = 1'b0;
      cfg_valid = 1'b0;
      cfg_ch    = '0;
      cfg_inc   = '0;
      cfg_en    = 1'b0;
      model_clear();
      test_reset();
      test_basic_rate();
      test_wrap();
      test_cfg_during_scan();
      test_run_drop();
      test_enable_off();
      test_random();
      test_reset_mid_scan();
      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
